// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter. Every grant is followed by a mandatory idle
// gap cycle, and a grant is revoked once it has been held for MAX_HOLD cycles.
module rr_arbiter4 #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] grant,
    output logic [1:0] grant_id,
    output logic       busy,
    output logic       timeout
);
    localparam int CW = $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    state_t        state_q, state_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [1:0]    id_q, id_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    grant_q, grant_d;
    logic          busy_q, busy_d;
    logic          tmo_q, tmo_d;
    logic [2:0]    pick;
    logic          lim_hit;

    // Returns {found, index} of the first set request at or above p, wrapping 3->0.
    function automatic logic [2:0] first_req(input logic [3:0] r, input logic [1:0] p);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = p + 2'(k);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    assign pick    = first_req(req, ptr_q);
    assign lim_hit = (cnt_q == CW'(MAX_HOLD));

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        tmo_d   = 1'b0;
        case (state_q)
            IDLE, GAP: begin
                if (pick[2]) begin
                    state_d = GRANT;
                    id_d    = pick[1:0];
                    grant_d = 4'b0001 << pick[1:0];
                    cnt_d   = CW'(1);
                end else begin
                    state_d = IDLE;
                    grant_d = 4'b0000;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (done || !req[id_q] || lim_hit) begin
                    state_d = GAP;
                    grant_d = 4'b0000;
                    ptr_d   = id_q + 2'd1;
                    cnt_d   = '0;
                    // A limit release that coincides with a normal release is not a timeout.
                    tmo_d   = !done && req[id_q];
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 4'b0000;
                cnt_d   = '0;
            end
        endcase
        busy_d = |grant_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            id_q    <= 2'd0;
            cnt_q   <= '0;
            grant_q <= 4'b0000;
            busy_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
            tmo_q   <= tmo_d;
        end
    end

    assign grant    = grant_q;
    assign grant_id = id_q;
    assign busy     = busy_q;
    assign timeout  = tmo_q;
endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4: expected outputs are queued as each step is
// driven and compared one edge later; a MAX_HOLD=1 instance shares the inputs.
module tb_rr_arbiter4;
    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic       done;
    logic [3:0] grant, grant1;
    logic [1:0] grant_id, grant_id1;
    logic       busy, busy1, timeout, timeout1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string      tag;
        logic [3:0] g;
        logic [1:0] id;
        logic       t;
        logic       chk_id;
        logic       h1;
    } exp_t;

    exp_t sb[$];

    rr_arbiter4 #(.MAX_HOLD(8)) dut (
        .clk(clk), .reset(reset), .req(req), .done(done),
        .grant(grant), .grant_id(grant_id), .busy(busy), .timeout(timeout)
    );

    rr_arbiter4 #(.MAX_HOLD(1)) dut1 (
        .clk(clk), .reset(reset), .req(req), .done(done),
        .grant(grant1), .grant_id(grant_id1), .busy(busy1), .timeout(timeout1)
    );

    always #5 clk = ~clk;

    task automatic push(input string tag, input logic [3:0] g, input logic [1:0] id,
                        input logic t, input logic chk_id, input logic h1);
        exp_t e;
        e.tag = tag; e.g = g; e.id = id; e.t = t; e.chk_id = chk_id; e.h1 = h1;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        logic [3:0] og;
        logic [1:0] oid;
        logic ob, ot;
        checks++;
        assert (sb.size() > 0) else begin
            failures++;
            $error("FAIL scoreboard_empty got=0 exp=>0");
        end
        if (sb.size() > 0) begin
            e   = sb.pop_front();
            og  = e.h1 ? grant1    : grant;
            oid = e.h1 ? grant_id1 : grant_id;
            ob  = e.h1 ? busy1     : busy;
            ot  = e.h1 ? timeout1  : timeout;
            checks++;
            assert (og === e.g) else begin
                failures++;
                $error("FAIL %s grant got=%b exp=%b", e.tag, og, e.g);
            end
            checks++;
            assert (ob === (|e.g)) else begin
                failures++;
                $error("FAIL %s busy got=%b exp=%b", e.tag, ob, |e.g);
            end
            checks++;
            assert (ot === e.t) else begin
                failures++;
                $error("FAIL %s timeout got=%b exp=%b", e.tag, ot, e.t);
            end
            if (e.chk_id) begin
                checks++;
                assert (oid === e.id) else begin
                    failures++;
                    $error("FAIL %s grant_id got=%0d exp=%0d", e.tag, oid, e.id);
                end
            end
        end
    endtask

    // Drive one cycle of inputs, expect the given outputs right after the next edge.
    task automatic cyc(input logic [3:0] r, input logic d, input string tag,
                       input logic [3:0] g, input logic [1:0] id, input logic t);
        req = r; done = d;
        push(tag, g, id, t, |g, 1'b0);
        @(posedge clk); #1;
        check_out();
    endtask

    task automatic cyc1(input logic [3:0] r, input string tag,
                        input logic [3:0] g, input logic t);
        req = r; done = 1'b0;
        push(tag, g, 2'd0, t, |g, 1'b1);
        @(posedge clk); #1;
        check_out();
    endtask

    task automatic do_reset(input string tag);
        req = 4'b0000; done = 1'b0; reset = 1'b1;
        #2;
        push(tag, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0);
        check_out();
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; req = 4'b0000; done = 1'b0;
        #1;
        do_reset("reset_state");

        // single request, done on the 3rd grant cycle, then ptr=3 shows via 1111
        cyc(4'b0100, 1'b0, "single_g1", 4'b0100, 2'd2, 1'b0);
        cyc(4'b0100, 1'b0, "single_g2", 4'b0100, 2'd2, 1'b0);
        cyc(4'b0100, 1'b0, "single_g3", 4'b0100, 2'd2, 1'b0);
        cyc(4'b0100, 1'b1, "single_rel", 4'b0000, 2'd0, 1'b0);
        cyc(4'b0000, 1'b0, "single_idle", 4'b0000, 2'd0, 1'b0);
        cyc(4'b1111, 1'b0, "ptr_is_3", 4'b1000, 2'd3, 1'b0);
        cyc(4'b0000, 1'b0, "drop_gap", 4'b0000, 2'd0, 1'b0);
        cyc(4'b0001, 1'b0, "ptr_wrap0", 4'b0001, 2'd0, 1'b0);

        // round-robin with done every grant cycle
        do_reset("reset_rr");
        cyc(4'b1111, 1'b1, "rr_0", 4'b0001, 2'd0, 1'b0);
        cyc(4'b1111, 1'b1, "rr_gap0", 4'b0000, 2'd0, 1'b0);
        cyc(4'b1111, 1'b1, "rr_1", 4'b0010, 2'd1, 1'b0);
        cyc(4'b1111, 1'b1, "rr_gap1", 4'b0000, 2'd0, 1'b0);
        cyc(4'b1111, 1'b1, "rr_2", 4'b0100, 2'd2, 1'b0);
        cyc(4'b1111, 1'b1, "rr_gap2", 4'b0000, 2'd0, 1'b0);
        cyc(4'b1111, 1'b1, "rr_3", 4'b1000, 2'd3, 1'b0);
        cyc(4'b1111, 1'b1, "rr_gap3", 4'b0000, 2'd0, 1'b0);
        cyc(4'b1111, 1'b1, "rr_wrap", 4'b0001, 2'd0, 1'b0);

        // hold limit: 8 grant cycles, timeout gap, regrant; then done/limit tie
        do_reset("reset_tmo");
        for (int i = 0; i < 8; i++)
            cyc(4'b0001, 1'b0, $sformatf("tmo_hold%0d", i + 1), 4'b0001, 2'd0, 1'b0);
        cyc(4'b0001, 1'b0, "tmo_gap", 4'b0000, 2'd0, 1'b1);
        cyc(4'b0001, 1'b0, "tmo_regrant", 4'b0001, 2'd0, 1'b0);
        for (int i = 0; i < 7; i++)
            cyc(4'b0001, 1'b0, $sformatf("tie_hold%0d", i + 2), 4'b0001, 2'd0, 1'b0);
        cyc(4'b0001, 1'b1, "tie_rel", 4'b0000, 2'd0, 1'b0);
        cyc(4'b0001, 1'b0, "tie_regrant", 4'b0001, 2'd0, 1'b0);

        // owner drop, with non-owner churn during the grant
        do_reset("reset_drop");
        cyc(4'b0011, 1'b0, "drop_own0", 4'b0001, 2'd0, 1'b0);
        cyc(4'b0111, 1'b0, "nonowner_chg", 4'b0001, 2'd0, 1'b0);
        cyc(4'b1011, 1'b0, "nonowner_chg2", 4'b0001, 2'd0, 1'b0);
        cyc(4'b0010, 1'b0, "drop_gap", 4'b0000, 2'd0, 1'b0);
        cyc(4'b0010, 1'b0, "drop_next", 4'b0010, 2'd1, 1'b0);

        // MAX_HOLD=1 instance: every grant lasts one cycle and ends in a timeout gap
        do_reset("reset_h1");
        cyc1(4'b0001, "h1_g1", 4'b0001, 1'b0);
        cyc1(4'b0001, "h1_gap1", 4'b0000, 1'b1);
        cyc1(4'b0001, "h1_g2", 4'b0001, 1'b0);
        cyc1(4'b0001, "h1_gap2", 4'b0000, 1'b1);

        // reset between edges while 1000 is granted
        do_reset("reset_mid");
        cyc(4'b1000, 1'b0, "mid_grant", 4'b1000, 2'd3, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        push("mid_async", 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0);
        check_out();
        @(posedge clk); #1;
        push("mid_held", 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0);
        check_out();
        reset = 1'b0;
        cyc(4'b1001, 1'b0, "mid_resume", 4'b0001, 2'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
